// File: rtl/xor_dec_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : xor_dec_pkg
//  Brief    : Shared types and constants for the XOR pair decoder.
//  Revision : 1.0  initial release
// ============================================================================
package xor_dec_pkg;

    // FSM encoding, kept as plain constants for compatibility with older tools
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_LANE0 = 2'd1;
    localparam state_t c_ST_LANE1 = 2'd2;

    // Output lane tag
    typedef logic lane_t;
    localparam lane_t c_LANE0 = 1'b0;
    localparam lane_t c_LANE1 = 1'b1;

endpackage : xor_dec_pkg
`default_nettype wire

// File: rtl/xor_dec_lane.sv
`default_nettype none
// ============================================================================
//  Module   : xor_dec_lane
//  Brief    : Registered hold slot for one recovered word (load / keep).
//  Revision : 1.0  initial release
// ============================================================================
module xor_dec_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // Capture the word when loaded, otherwise keep it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule : xor_dec_lane
`default_nettype wire

// File: rtl/xor_pair_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : xor_pair_decoder
//  Brief    : Recovers v0=w0^u0 / v1=w1^u1 from a paired-lane beat and emits
//             them serially (lane 0 then lane 1) on a registered valid/ready
//             stream; counts pairs whose lane-1 word was consumed.
//  Options  : XOR_DEC_PARITY_EN adds in_par / par_err beat parity checking.
//  Revision : 1.0  initial release
// ============================================================================
module xor_pair_decoder
    import xor_dec_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] u0,
    input  logic [WIDTH-1:0] u1,
    input  logic [WIDTH-1:0] w0,
    input  logic [WIDTH-1:0] w1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_lane,
    output logic [CNT_W-1:0] pair_cnt
`ifdef XOR_DEC_PARITY_EN
    ,
    input  logic             in_par,
    output logic             par_err
`endif
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    lane_t            r_out_lane;
    logic [CNT_W-1:0] r_pair_cnt;

    logic             w_accept;
    logic [WIDTH-1:0] w_v0;
    logic [WIDTH-1:0] w_v1;
    logic [WIDTH-1:0] w_v1_held;

    // A new beat is taken when idle, or when the lane-1 word leaves this cycle
    assign in_ready = (r_state == c_ST_IDLE) ||
                      ((r_state == c_ST_LANE1) && out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_v0     = w0 ^ u0;
    assign w_v1     = w1 ^ u1;

    // Lane-1 word waits here while lane 0 is on the output
    xor_dec_lane #(
        .WIDTH (WIDTH)
    ) u_hold_v1 (
        .clk  (clk),
        .rst  (rst),
        .load (w_accept),
        .d    (w_v1),
        .q    (w_v1_held)
    );

    // Sequencer: lane 0, lane 1, then either the next beat or idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_lane  <= c_LANE0;
            r_pair_cnt  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_out_data  <= w_v0;
                        r_out_lane  <= c_LANE0;
                        r_out_valid <= 1'b1;
                        r_state     <= c_ST_LANE0;
                    end
                end
                c_ST_LANE0: begin
                    if (out_ready) begin
                        r_out_data <= w_v1_held;
                        r_out_lane <= c_LANE1;
                        r_state    <= c_ST_LANE1;
                    end
                end
                c_ST_LANE1: begin
                    if (out_ready) begin
                        r_pair_cnt <= r_pair_cnt + c_CNT_ONE;
                        if (in_valid) begin
                            r_out_data <= w_v0;
                            r_out_lane <= c_LANE0;
                            r_state    <= c_ST_LANE0;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_state     <= c_ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_lane  = r_out_lane;
    assign pair_cnt  = r_pair_cnt;

`ifdef XOR_DEC_PARITY_EN
    logic r_par_err;

    // Flag a beat whose combined parity disagrees with the sender's bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= w_accept && ((^(w_v0 ^ w_v1)) != in_par);
        end
    end

    assign par_err = r_par_err;
`endif

endmodule : xor_pair_decoder
`default_nettype wire

// File: tb/tb_xor_pair_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xor_pair_decoder
//  Brief    : Directed, table-driven bench for xor_pair_decoder (CNT_W=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_xor_pair_decoder;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] u0 = '0, u1 = '0, w0 = '0, w1 = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_lane;
    logic [CNT_W-1:0] pair_cnt;
`ifdef XOR_DEC_PARITY_EN
    logic             in_par = 1'b0;
    logic             par_err;
`endif

    xor_pair_decoder #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .u0        (u0),
        .u1        (u1),
        .w0        (w0),
        .w1        (w1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .pair_cnt  (pair_cnt)
`ifdef XOR_DEC_PARITY_EN
        ,
        .in_par    (in_par),
        .par_err   (par_err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt  = 0;

    typedef struct {
        logic       iv;
        logic       ordy;
        logic [7:0] u0, w0, u1, w1;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_data;
        logic       e_lane;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // One clock, leaving us 1 time unit past the rising edge
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic ordy,
                         input logic [7:0] a0, input logic [7:0] b0,
                         input logic [7:0] a1, input logic [7:0] b1);
        in_valid  = iv;
        out_ready = ordy;
        u0 = a0; w0 = b0; u1 = a1; w1 = b1;
        #1;
    endtask

    // n back-to-back pairs with out_ready held high; starts and ends idle
    task automatic send_pairs(input int n, input logic [7:0] seed);
        logic [7:0] s, ev0, ev1;
        for (int c = 0; c < 2 * n; c++) begin
            s   = seed + 8'(c / 2);
            ev0 = s ^ 8'h30;
            ev1 = (~s) ^ 8'hC0;
            drive(1'b1, 1'b1, s, 8'h30, ~s, 8'hC0);
            chk("b2b_in_ready", 32'(in_ready), 32'((c % 2) == 0));
            cycle();
            if (c > 0 && (c % 2) == 0) exp_cnt = (exp_cnt + 1) % 16;
            chk("b2b_valid", 32'(out_valid), 32'd1);
            chk("b2b_lane", 32'(out_lane), 32'(c % 2));
            chk("b2b_data", 32'(out_data), 32'((c % 2) ? ev1 : ev0));
            chk("b2b_cnt", 32'(pair_cnt), 32'(exp_cnt));
        end
        drive(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
        cycle();
        exp_cnt = (exp_cnt + 1) % 16;
        chk("b2b_end_valid", 32'(out_valid), 32'd0);
        chk("b2b_end_cnt", 32'(pair_cnt), 32'(exp_cnt));
    endtask

    initial begin
        //            iv ordy u0     w0     u1     w1    ir  ov  data  lane cnt
        vecs[0] = '{1'b1, 1'b1, 8'h0F, 8'hFF, 8'hAA, 8'h55, 1'b1, 1'b1, 8'hF0, 1'b0, 4'd0};
        vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b1, 4'd0};
        vecs[2] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 4'd1};
        vecs[3] = '{1'b1, 1'b0, 8'h12, 8'h34, 8'h56, 8'h78, 1'b1, 1'b1, 8'h26, 1'b0, 4'd1};
        vecs[4] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h26, 1'b0, 4'd1};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h2E, 1'b1, 4'd1};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h2E, 1'b1, 4'd1};
        vecs[7] = '{1'b1, 1'b1, 8'hA5, 8'h5A, 8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, 4'd2};
        vecs[8] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b1, 4'd2};
        vecs[9] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'd3};

        // Reset state
        cycle(); cycle(); cycle();
        rst = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_lane", 32'(out_lane), 32'd0);
        chk("rst_cnt", 32'(pair_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef XOR_DEC_PARITY_EN
        chk("rst_par_err", 32'(par_err), 32'd0);
`endif

        // Single pair, backpressure on lane 1, pair followed by idle
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].iv, vecs[i].ordy, vecs[i].u0, vecs[i].w0, vecs[i].u1, vecs[i].w1);
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
            cycle();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            if (vecs[i].e_ov) begin
                chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].e_data));
                chk($sformatf("vec%0d_lane", i), 32'(out_lane), 32'(vecs[i].e_lane));
            end
            chk($sformatf("vec%0d_cnt", i), 32'(pair_cnt), 32'(vecs[i].e_cnt));
        end
        exp_cnt = 3;

        // Back-to-back: 10 beats, 20 words without a bubble
        send_pairs(10, 8'h40);
        chk("b2b_total_cnt", 32'(pair_cnt), 32'd13);

        // Backpressure in LANE0 for 5 cycles
        drive(1'b1, 1'b0, 8'h11, 8'h22, 8'h44, 8'h88);
        cycle();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 8'(k), 8'hE7, 8'(k), 8'h3C);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            cycle();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", 32'(out_data), 32'h33);
            chk("bp_lane", 32'(out_lane), 32'd0);
        end
        drive(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
        cycle();
        chk("bp_l1_data", 32'(out_data), 32'hCC);
        chk("bp_l1_lane", 32'(out_lane), 32'd1);
        cycle();
        chk("bp_end_valid", 32'(out_valid), 32'd0);
        chk("bp_end_cnt", 32'(pair_cnt), 32'd14);

        // Reset mid-LANE0 for 2 cycles
        drive(1'b1, 1'b0, 8'h01, 8'h02, 8'h03, 8'h04);
        cycle();
        chk("mid_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        drive(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
        cycle(); cycle();
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_cnt", 32'(pair_cnt), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        cycle();
        chk("mid_rst_no_partial", 32'(out_valid), 32'd0);
        drive(1'b1, 1'b1, 8'h77, 8'h00, 8'h0F, 8'hF0);
        cycle();
        chk("post_rst_lane", 32'(out_lane), 32'd0);
        chk("post_rst_data", 32'(out_data), 32'h77);
        drive(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
        cycle();
        chk("post_rst_l1", 32'(out_data), 32'hFF);
        cycle();
        chk("post_rst_cnt", 32'(pair_cnt), 32'd1);
        exp_cnt = 1;

        // Wrap: 16 more pairs makes 17 since reset -> counter reads 1
        send_pairs(16, 8'h90);
        chk("wrap_cnt", 32'(pair_cnt), 32'd1);

`ifdef XOR_DEC_PARITY_EN
        // v0^v1 = 8'h01 (odd parity)
        in_par = 1'b0;
        drive(1'b1, 1'b1, 8'h01, 8'h00, 8'h00, 8'h00);
        cycle();
        chk("par_err_hit", 32'(par_err), 32'd1);
        drive(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
        cycle();
        chk("par_err_pulse", 32'(par_err), 32'd0);
        cycle();
        in_par = 1'b1;
        drive(1'b1, 1'b1, 8'h01, 8'h00, 8'h00, 8'h00);
        cycle();
        chk("par_ok", 32'(par_err), 32'd0);
        chk("par_ok_data", 32'(out_data), 32'h01);
        drive(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
        cycle(); cycle();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule : tb_xor_pair_decoder
`default_nettype wire
